inv_add_round_key: RTL and testbench

Registered AddRoundKey stage and round sequencer for the AES-128 decryption datapath. It captures the ciphertext, XORs in round keys 10 down to 0 fetched from the key store, and presents each result to the `inv_mix_column` input. For the initial and final rounds, the `mix_en` flag tells downstream logic to bypass `inv_mix_column`. Between rounds it waits for the InvShiftRows/InvSubBytes path to return the next state.

---
 rtl/inv_add_round_key.sv | 123 ++++++++++++
 tb/tb_inv_add_round_key.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : inv_add_round_key
// Description : Registered AddRoundKey stage and round sequencer for the
//               AES-128 decryption datapath. It captures a ciphertext block,
//               XORs in round keys 10 down to 0 fetched from the key store,
//               and presents each result to inv_mix_column. Between rounds it
//               waits for the InvShiftRows/InvSubBytes path to return the
//               next state.
// Ports       : clk, n_rst (async, active-low)
//               start, cipher_in            - begin a block (sampled in IDLE)
//               state_in, state_in_valid    - state back from inv_sub_bytes
//               round_key, key_valid        - key store response
//               key_req, key_round          - key store request
//               state_array_out, out_valid, mix_en - result to inv_mix_column
//               busy, done                  - status
// Revision    : 1.0 - initial release
// ============================================================================
module inv_add_round_key (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [0:15][7:0]  cipher_in,
    input  logic [0:15][7:0]  state_in,
    input  logic              state_in_valid,
    input  logic [0:15][7:0]  round_key,
    input  logic              key_valid,
    output logic              key_req,
    output logic [3:0]        key_round,
    output logic [0:15][7:0]  state_array_out,
    output logic              out_valid,
    output logic              mix_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_KEY_REQ    = 3'd1,
        S_WAIT_KEY   = 3'd2,
        S_OUTPUT     = 3'd3,
        S_WAIT_STATE = 3'd4
    } state_t;

    localparam logic [3:0] c_FIRST_ROUND = 4'd10;

    state_t           state_q, state_d;
    logic [0:15][7:0] state_reg_q, state_reg_d;
    logic [3:0]       round_cnt_q, round_cnt_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            state_reg_q <= '0;
            round_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg_q;
        round_cnt_d = round_cnt_q;
        key_req     = 1'b0;
        key_round   = 4'd0;
        out_valid   = 1'b0;
        mix_en      = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_reg_d = cipher_in;
                    round_cnt_d = c_FIRST_ROUND;
                    state_d     = S_KEY_REQ;
                end
            end
            S_KEY_REQ: begin
                key_req   = 1'b1;
                key_round = round_cnt_q;
                state_d   = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                // Keep the index stable so a slow key store can still use it.
                key_round = round_cnt_q;
                if (key_valid) begin
                    state_reg_d = state_reg_q ^ round_key;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                // Initial (10) and final (0) rounds skip InvMixColumns.
                mix_en    = (round_cnt_q != 4'd0) && (round_cnt_q != c_FIRST_ROUND);
                if (round_cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    round_cnt_d = round_cnt_q - 4'd1;
                    state_d     = S_WAIT_STATE;
                end
            end
            S_WAIT_STATE: begin
                if (state_in_valid) begin
                    state_reg_d = state_in;
                    state_d     = S_KEY_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result register drives the output directly and holds through IDLE.
    assign state_array_out = state_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_add_round_key
// Description : Self-checking bench for inv_add_round_key. Each block is
//               described by a per-round table of {input block, round key,
//               expected XOR result}; the bench plays the key store and the
//               inv_sub_bytes return path from that table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_add_round_key;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic [0:15][7:0]  cipher_in;
    logic [0:15][7:0]  state_in;
    logic              state_in_valid;
    logic [0:15][7:0]  round_key;
    logic              key_valid;
    logic              key_req;
    logic [3:0]        key_round;
    logic [0:15][7:0]  state_array_out;
    logic              out_valid;
    logic              mix_en;
    logic              busy;
    logic              done;

    inv_add_round_key dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .start           (start),
        .cipher_in       (cipher_in),
        .state_in        (state_in),
        .state_in_valid  (state_in_valid),
        .round_key       (round_key),
        .key_valid       (key_valid),
        .key_req         (key_req),
        .key_round       (key_round),
        .state_array_out (state_array_out),
        .out_valid       (out_valid),
        .mix_en          (mix_en),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per round: tbl[10].blk is the ciphertext, tbl[r].blk for
    // r < 10 is the state handed back before round r.
    typedef struct {
        logic [127:0] blk;
        logic [127:0] key;
        logic [127:0] exp;
    } rnd_t;

    rnd_t tbl [0:10];

    int n_vec = 0;
    int n_bad = 0;

    // Pulse monitor
    int         oc = 0;
    int         kc = 0;
    logic [3:0] krq [$];

    always @(negedge clk) begin
        if (n_rst) begin
            if (out_valid) oc++;
            if (key_req) begin
                kc++;
                krq.push_back(key_round);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: AddRoundKey is a plain 128-bit XOR of block and key.
    function automatic void fill_random();
        for (int r = 0; r <= 10; r++) begin
            tbl[r].blk = rnd128();
            tbl[r].key = rnd128();
            tbl[r].exp = tbl[r].blk ^ tbl[r].key;
        end
    endfunction

    function automatic logic exp_mix(input int r);
        return (r >= 1) && (r <= 9);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_key_req"},   key_req,   0);
        chk({tag, "_key_round"}, key_round, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_mix_en"},    mix_en,    0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_state_out"}, state_array_out, 0);
    endtask

    // Plays a whole block through the DUT. Must be entered while the DUT
    // is in IDLE; returns after the first IDLE cycle following done, so a
    // follow-on call starts back-to-back.
    task automatic run_block(input int kd, input int sd, input bit spur);
        int oc0;
        int kc0;
        oc0 = oc;
        kc0 = kc;
        krq.delete();
        cipher_in = tbl[10].blk;
        start     = 1'b1;
        tick;
        start     = 1'b0;
        cipher_in = rnd128();
        for (int r = 10; r >= 0; r--) begin
            chk("key_req", key_req, 1);
            chk("key_round", key_round, r);
            chk("busy", busy, 1);
            tick;
            for (int i = 0; i < kd; i++) begin
                chk("stall_key_round", key_round, r);
                chk("stall_no_out", out_valid, 0);
                if (spur && i == 0) begin
                    state_in_valid = 1'b1;
                    state_in       = rnd128();
                    start          = 1'b1;
                end else begin
                    state_in_valid = 1'b0;
                    start          = 1'b0;
                end
                tick;
            end
            state_in_valid = 1'b0;
            start          = 1'b0;
            key_valid      = 1'b1;
            round_key      = tbl[r].key;
            tick;
            key_valid      = 1'b0;
            round_key      = rnd128();
            chk("out_valid", out_valid, 1);
            chk("state_out", state_array_out, tbl[r].exp);
            chk("mix_en", mix_en, exp_mix(r));
            chk("done", done, (r == 0));
            if (r > 0) begin
                tick;
                for (int i = 0; i < sd; i++) begin
                    chk("wait_no_out", out_valid, 0);
                    chk("wait_no_req", key_req, 0);
                    if (spur && i == 0) begin
                        key_valid = 1'b1;
                        round_key = rnd128();
                        start     = 1'b1;
                    end else begin
                        key_valid = 1'b0;
                        start     = 1'b0;
                    end
                    tick;
                end
                key_valid      = 1'b0;
                start          = 1'b0;
                state_in       = tbl[r-1].blk;
                state_in_valid = 1'b1;
                tick;
                state_in_valid = 1'b0;
                state_in       = rnd128();
            end
        end
        tick;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_hold", state_array_out, tbl[0].exp);
        chk("out_valid_count", oc - oc0, 11);
        chk("key_req_count", kc - kc0, 11);
        for (int i = 0; i < krq.size(); i++) begin
            chk("key_round_seq", krq[i], 10 - i);
        end
    endtask

    initial begin
        n_rst          = 1'b0;
        start          = 1'b0;
        cipher_in      = '0;
        state_in       = '0;
        state_in_valid = 1'b0;
        round_key      = '0;
        key_valid      = 1'b0;

        // Reset state
        tick;
        check_all_zero("reset");
        tick;
        n_rst = 1'b1;
        tick;
        check_all_zero("post_reset");

        // Known-answer block (FIPS-197 inverse cipher), middle rounds random.
        fill_random();
        tbl[10].blk = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tbl[10].key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        tbl[10].exp = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
        tbl[9].blk  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
        tbl[9].key  = 128'h549932d1f08557681093ed9cbe2c974e;
        tbl[9].exp  = 128'he9f74eec023020f61bf2ccf2353c21c7;
        // Output of inv_sub_bytes ahead of the last AddRoundKey.
        tbl[0].blk  = 128'h00102030405060708090a0b0c0d0e0f0;
        tbl[0].key  = 128'h000102030405060708090a0b0c0d0e0f;
        tbl[0].exp  = 128'h00112233445566778899aabbccddeeff;
        run_block(0, 0, 1'b0);

        // Plaintext held in IDLE; spurious inputs there are ignored.
        key_valid      = 1'b1;
        state_in_valid = 1'b1;
        state_in       = rnd128();
        round_key      = rnd128();
        tick;
        key_valid      = 1'b0;
        state_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_plain", state_array_out, 128'h00112233445566778899aabbccddeeff);
            chk("hold_no_out", out_valid, 0);
            chk("hold_busy", busy, 0);
            tick;
        end

        // Asynchronous reset in WAIT_KEY, then restart from round 10.
        cipher_in = rnd128();
        start     = 1'b1;
        tick;
        start     = 1'b0;
        tick;
        chk("pre_rst_key_round", key_round, 10);
        #2 n_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick;
        tick;
        n_rst = 1'b1;
        tick;
        fill_random();
        run_block(1, 2, 1'b0);

        // Long stalls with spurious inputs.
        tick;
        fill_random();
        run_block(5, 7, 1'b1);

        // Back-to-back blocks with random stalls.
        for (int n = 0; n < 3; n++) begin
            fill_random();
            run_block($urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
